// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory SRAM arbiter slice.
package dm_arb_pkg;

    localparam int DM_PORTS   = 2;
    localparam int DM_DATA_W  = 32;
    localparam int DM_ADDR_W  = 32;

    // Arbitration policies understood by rr_arb2
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // One requester's command as seen after port selection
    typedef struct packed {
        logic                   write;
        logic [DM_ADDR_W-1:0]   addr;
        logic [DM_DATA_W/8-1:0] wstrb;
        logic [DM_DATA_W-1:0]   wdata;
    } req_t;

    // Expand byte enables into the macro's active-low per-bit write mask
    function automatic logic [DM_DATA_W-1:0] strbToBweb(input logic [DM_DATA_W/8-1:0] strb);
        logic [DM_DATA_W-1:0] mask;
        mask = '1;
        for (int k = 0; k < DM_DATA_W/8; k++) begin
            mask[8*k +: 8] = {8{~strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed priority with port 0 on top.
module rr_arb2
    import dm_arb_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_elig,
    output logic [1:0] o_grant
);

    // 1 = port 1 was granted most recently, so port 0 wins the next tie
    logic r_last_p1;

    // Pick at most one eligible port; only a two-way tie consults the pointer
    always_comb begin
        o_grant = '0;
        if (PRIO_MODE == PRIO_FIXED) begin
            if (i_elig[0]) begin
                o_grant = 2'b01;
            end else if (i_elig[1]) begin
                o_grant = 2'b10;
            end
        end else begin
            case (i_elig)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last_p1 ? 2'b01 : 2'b10;
                default: o_grant = '0;
            endcase
        end
    end

    // Remember the last winner; idle cycles leave the pointer untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_p1 <= 1'b1;
        end else if (|o_grant) begin
            r_last_p1 <= o_grant[1];
        end
    end

endmodule

// File: rtl/dm_sram_arbiter.sv
// Two-port arbiter/sequencer in front of the data-memory SRAM macro.
// Drives the macro strobes for the granted port and buffers read data per port
// so requesters never observe the raw macro output after its valid cycle.
module dm_sram_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W    = DM_DATA_W,
    parameter int SRAM_AW   = 14,
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DM_PORTS-1:0]                   req_valid,
    output logic [DM_PORTS-1:0]                   req_ready,
    input  logic [DM_PORTS-1:0]                   req_write,
    input  logic [DM_PORTS-1:0][DM_ADDR_W-1:0]    req_addr,
    input  logic [DM_PORTS-1:0][DATA_W/8-1:0]     req_wstrb,
    input  logic [DM_PORTS-1:0][DATA_W-1:0]       req_wdata,
    output logic [DM_PORTS-1:0]                   rsp_valid,
    input  logic [DM_PORTS-1:0]                   rsp_ready,
    output logic [DM_PORTS-1:0][DATA_W-1:0]       rsp_rdata,
    output logic                                  sram_ceb,
    output logic                                  sram_web,
    output logic [DATA_W-1:0]                     sram_bweb,
    output logic [SRAM_AW-1:0]                    sram_a,
    output logic [DATA_W-1:0]                     sram_di,
    input  logic [DATA_W-1:0]                     sram_do
);

    logic [DM_PORTS-1:0]             w_elig;
    logic [DM_PORTS-1:0]             w_grant;
    logic [DM_PORTS-1:0]             w_rd_issue;
    logic                            w_gidx;
    req_t                            w_sel;
    logic                            w_unused;

    logic [DM_PORTS-1:0]             r_rsp_valid;
    logic [DM_PORTS-1:0]             r_fresh;
    logic [DM_PORTS-1:0][DATA_W-1:0] r_hold;

    // A port may compete unless it still owes an unaccepted response; reset masks everyone
    always_comb begin
        for (int i = 0; i < DM_PORTS; i++) begin
            w_elig[i] = rst && req_valid[i] && !(r_rsp_valid[i] && !rsp_ready[i]);
        end
    end

    rr_arb2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    assign w_gidx = w_grant[1];
    assign w_sel  = '{write: req_write[w_gidx], addr: req_addr[w_gidx],
                      wstrb: req_wstrb[w_gidx], wdata: req_wdata[w_gidx]};

    // Byte-offset and upper address bits never reach the word-addressed macro
    assign w_unused = ^{w_sel.addr[DM_ADDR_W-1:SRAM_AW+2], w_sel.addr[1:0]};

    // Steer the granted request onto the macro pins; idle pins park at read/disabled/zero
    always_comb begin
        req_ready = w_grant;
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (|w_grant) begin
            sram_ceb = 1'b0;
            sram_a   = w_sel.addr[SRAM_AW+1:2];
            if (w_sel.write) begin
                sram_web  = 1'b0;
                sram_bweb = strbToBweb(w_sel.wstrb);
                sram_di   = w_sel.wdata;
            end
        end
    end

    assign w_rd_issue = w_grant & {DM_PORTS{~w_sel.write}};

    // Track outstanding responses and capture macro data during its one valid cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= '0;
            r_fresh     <= '0;
            r_hold      <= '0;
        end else begin
            for (int i = 0; i < DM_PORTS; i++) begin
                r_fresh[i] <= w_rd_issue[i];
                if (w_rd_issue[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                end else if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
                if (r_fresh[i]) begin
                    r_hold[i] <= sram_do;
                end
            end
        end
    end

    // Present live macro data in the return cycle, the held copy afterwards
    always_comb begin
        for (int i = 0; i < DM_PORTS; i++) begin
            rsp_rdata[i] = r_fresh[i] ? sram_do : r_hold[i];
        end
    end

    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_dm_sram_arbiter.sv
// Directed bench for dm_sram_arbiter with a transaction-level reference model.
module tb_dm_sram_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        reqValid, reqReady, reqWrite, rspValid, rspReady;
    logic [1:0][31:0]  reqAddr, reqWdata, rspRdata;
    logic [1:0][3:0]   reqWstrb;
    logic              sramCeb, sramWeb;
    logic [31:0]       sramBweb, sramDi, sramDo;
    logic [13:0]       sramA;

    logic [1:0]        reqReadyF, rspValidF;
    logic [1:0][31:0]  rspRdataF;
    logic              sramCebF, sramWebF;
    logic [31:0]       sramBwebF, sramDiF, sramDoF;
    logic [13:0]       sramAF;

    logic [31:0]       tbMem  [0:16383];
    logic [31:0]       refMem [0:16383];

    logic [1:0]        mValid;
    logic [1:0][31:0]  mData;
    int                mLast;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    dm_sram_arbiter #(.DATA_W(32), .SRAM_AW(14), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wstrb(reqWstrb), .req_wdata(reqWdata),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata),
        .sram_ceb(sramCeb), .sram_web(sramWeb), .sram_bweb(sramBweb),
        .sram_a(sramA), .sram_di(sramDi), .sram_do(sramDo)
    );

    // Fixed-priority copy sharing the same request stimulus; only its grants are examined
    dm_sram_arbiter #(.DATA_W(32), .SRAM_AW(14), .PRIO_MODE(1)) dutF (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReadyF), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wstrb(reqWstrb), .req_wdata(reqWdata),
        .rsp_valid(rspValidF), .rsp_ready(rspReady), .rsp_rdata(rspRdataF),
        .sram_ceb(sramCebF), .sram_web(sramWebF), .sram_bweb(sramBwebF),
        .sram_a(sramAF), .sram_di(sramDiF), .sram_do(sramDoF)
    );

    assign sramDoF = 32'h0;

    // Behavioural SRAM macro: masked write, one-cycle read latency, DO holds otherwise
    always @(posedge clk) begin
        if (!sramCeb) begin
            if (!sramWeb) begin
                tbMem[sramA] <= (tbMem[sramA] & sramBweb) | (sramDi & ~sramBweb);
            end else begin
                sramDo <= tbMem[sramA];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWstrb = '0;
        reqWdata = '0;
        rspReady = 2'b11;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int port, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] strb, input logic [31:0] data);
        reqValid[port] = 1'b1;
        reqWrite[port] = wr;
        reqAddr[port]  = addr;
        reqWstrb[port] = strb;
        reqWdata[port] = data;
    endtask

    // Reference model: decides grants from the eligibility/tie rules and tracks
    // each port's owed response as a (valid, data) pair taken from a reference memory
    initial begin : compareProc
        logic [1:0]       elig, grant, sReady, sWrite;
        logic [1:0][31:0] sAddr, sWdata;
        logic [1:0][3:0]  sStrb;
        logic [31:0]      expBweb;
        logic [13:0]      wordA;
        bit               live;
        int               g;
        forever begin
            @(negedge clk);
            live = 1'b0;
            grant = '0;
            g = 0;
            if (!rst) begin
                mValid = '0;
                mData  = '0;
                mLast  = 1;
                checkOutput("rstReqReady", {30'd0, reqReady}, 32'd0);
                checkOutput("rstCeb", {31'd0, sramCeb}, 32'd1);
                checkOutput("rstWeb", {31'd0, sramWeb}, 32'd1);
                checkOutput("rstBweb", sramBweb, 32'hFFFF_FFFF);
                checkOutput("rstA", {18'd0, sramA}, 32'd0);
                checkOutput("rstDi", sramDi, 32'd0);
                checkOutput("rstRspValid", {30'd0, rspValid}, 32'd0);
                checkOutput("rstRdata0", rspRdata[0], 32'd0);
                checkOutput("rstRdata1", rspRdata[1], 32'd0);
            end else begin
                live   = 1'b1;
                sReady = rspReady;
                sWrite = reqWrite;
                sAddr  = reqAddr;
                sWdata = reqWdata;
                sStrb  = reqWstrb;
                for (int i = 0; i < 2; i++) begin
                    elig[i] = reqValid[i] && !(mValid[i] && !rspReady[i]);
                end
                if (elig == 2'b11) begin
                    grant = (mLast == 1) ? 2'b01 : 2'b10;
                end else begin
                    grant = elig;
                end
                g = grant[1] ? 1 : 0;
                checkOutput("reqReady", {30'd0, reqReady}, {30'd0, grant});
                checkOutput("ceb", {31'd0, sramCeb}, {31'd0, (grant == 2'b00)});
                if (grant != 2'b00) begin
                    checkOutput("addr", {18'd0, sramA}, {18'd0, sAddr[g][15:2]});
                    checkOutput("web", {31'd0, sramWeb}, {31'd0, !sWrite[g]});
                    expBweb = 32'hFFFF_FFFF;
                    if (sWrite[g]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (sStrb[g][k]) expBweb[8*k +: 8] = 8'h00;
                        end
                        checkOutput("di", sramDi, sWdata[g]);
                    end
                    checkOutput("bweb", sramBweb, expBweb);
                end else begin
                    checkOutput("idleWeb", {31'd0, sramWeb}, 32'd1);
                    checkOutput("idleBweb", sramBweb, 32'hFFFF_FFFF);
                    checkOutput("idleA", {18'd0, sramA}, 32'd0);
                    checkOutput("idleDi", sramDi, 32'd0);
                end
                checkOutput("rspValid", {30'd0, rspValid}, {30'd0, mValid});
                for (int i = 0; i < 2; i++) begin
                    if (mValid[i]) checkOutput("rspRdata", rspRdata[i], mData[i]);
                end
            end
            @(posedge clk);
            if (live && rst) begin
                for (int i = 0; i < 2; i++) begin
                    if (mValid[i] && sReady[i]) mValid[i] = 1'b0;
                end
                if (grant != 2'b00) begin
                    mLast = g;
                    wordA = sAddr[g][15:2];
                    if (sWrite[g]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (sStrb[g][k]) refMem[wordA][8*k +: 8] = sWdata[g][8*k +: 8];
                        end
                    end else begin
                        mValid[g] = 1'b1;
                        mData[g]  = refMem[wordA];
                    end
                end
            end
        end
    end

    // Directed scenarios with hand-computed literal expectations
    initial begin : stimProc
        for (int i = 0; i < 16384; i++) begin
            tbMem[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            tbMem[i] = 32'h1000_0000 + i;
        end
        tbMem[4]  = 32'hDEAD_BEEF;
        tbMem[5]  = 32'h5555_0005;
        tbMem[6]  = 32'h6666_0006;
        tbMem[7]  = 32'h7777_0007;
        tbMem[8]  = 32'hAABB_CCDD;
        tbMem[9]  = 32'h9999_0009;
        tbMem[10] = 32'hAAAA_000A;
        for (int i = 0; i < 16384; i++) begin
            refMem[i] = tbMem[i];
        end
        sramDo = 32'h0;
        rst = 1'b0;
        idle();
        #2;
        checkOutput("hRstReady", {30'd0, reqReady}, 32'd0);
        checkOutput("hRstCeb", {31'd0, sramCeb}, 32'd1);
        step(2);
        rst = 1'b1;
        step(1);

        // Single read of word 4
        applyStimulus(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        #2;
        checkOutput("hRdCeb", {31'd0, sramCeb}, 32'd0);
        checkOutput("hRdA", {18'd0, sramA}, 32'd4);
        step(1);
        idle();
        #2;
        checkOutput("hRdValid", {31'd0, rspValid[0]}, 32'd1);
        checkOutput("hRdData", rspRdata[0], 32'hDEAD_BEEF);
        step(1);

        // Byte write to word 8, then read it back
        applyStimulus(1, 1'b1, 32'h0000_0020, 4'b0101, 32'h1122_3344);
        #2;
        checkOutput("hWrBweb", sramBweb, 32'hFF00_FF00);
        checkOutput("hWrWeb", {31'd0, sramWeb}, 32'd0);
        checkOutput("hWrA", {18'd0, sramA}, 32'd8);
        step(1);
        idle();
        applyStimulus(1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
        step(1);
        idle();
        #2;
        checkOutput("hWrReadBack", rspRdata[1], 32'hAA22_CC44);
        step(1);

        // Contention: port 1 won last, so port 0 leads the alternation
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
            applyStimulus(1, 1'b0, 32'h0000_0004, 4'h0, 32'h0);
            #2;
            checkOutput("hRrGrant", {30'd0, reqReady}, (c % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("hFixGrant", {30'd0, reqReadyF}, 32'd1);
            step(1);
        end
        idle();
        step(1);

        // Backpressure on port 0 while port 1 keeps the macro busy
        applyStimulus(0, 1'b0, 32'h0000_0014, 4'h0, 32'h0);
        #2;
        checkOutput("hBpGrantA", {30'd0, reqReady}, 32'd1);
        step(1);
        rspReady[0] = 1'b0;
        reqAddr[0]  = 32'h0000_0018;
        applyStimulus(1, 1'b0, 32'h0000_001C, 4'h0, 32'h0);
        #2;
        checkOutput("hBpGrantB", {30'd0, reqReady}, 32'd2);
        checkOutput("hBpHoldB", rspRdata[0], 32'h5555_0005);
        step(1);
        applyStimulus(1, 1'b0, 32'h0000_0024, 4'h0, 32'h0);
        #2;
        checkOutput("hBpGrantC", {30'd0, reqReady}, 32'd2);
        checkOutput("hBpHoldC", rspRdata[0], 32'h5555_0005);
        step(1);
        applyStimulus(1, 1'b0, 32'h0000_0028, 4'h0, 32'h0);
        #2;
        checkOutput("hBpGrantD", {30'd0, reqReady}, 32'd2);
        checkOutput("hBpHoldD", rspRdata[0], 32'h5555_0005);
        step(1);
        rspReady[0] = 1'b1;
        reqValid[1] = 1'b0;
        #2;
        checkOutput("hBpGrantE", {30'd0, reqReady}, 32'd1);
        checkOutput("hBpHoldE", rspRdata[0], 32'h5555_0005);
        step(1);
        idle();
        #2;
        checkOutput("hBpNext", rspRdata[0], 32'h6666_0006);
        step(1);

        // Pipelined reads of words 0..3 on port 0
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b0, 32'(k * 4), 4'h0, 32'h0);
            #2;
            checkOutput("hPipeGrant", {30'd0, reqReady}, 32'd1);
            if (k > 0) begin
                checkOutput("hPipeValid", {31'd0, rspValid[0]}, 32'd1);
                checkOutput("hPipeData", rspRdata[0], 32'h1000_0000 + 32'(k - 1));
            end
            step(1);
        end
        idle();
        #2;
        checkOutput("hPipeLast", rspRdata[0], 32'h1000_0003);
        step(1);

        // Reset lands while a read response is outstanding
        applyStimulus(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        step(1);
        idle();
        #1;
        checkOutput("hPreRstValid", {31'd0, rspValid[0]}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("hRstDrop", {30'd0, rspValid}, 32'd0);
        checkOutput("hRstRdata", rspRdata[0], 32'd0);
        step(1);
        rst = 1'b1;
        #1;
        checkOutput("hNoStale", {30'd0, rspValid}, 32'd0);
        applyStimulus(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0000_0004, 4'h0, 32'h0);
        #1;
        checkOutput("hPostRstTie", {30'd0, reqReady}, 32'd1);
        step(1);
        idle();
        #2;
        checkOutput("hPostRstValid", {30'd0, rspValid}, 32'd1);
        checkOutput("hPostRstData", rspRdata[0], 32'h1000_0000);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
